// File: rtl/cam_if.sv
// Request/response bundle for cam_pipe. With CAM_TERNARY_EN defined the
// request also carries a per-bit care mask.
interface cam_if #(
  parameter int KEY_WIDTH  = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [KEY_WIDTH-1:0]  req_key;
`ifdef CAM_TERNARY_EN
  logic [KEY_WIDTH-1:0]  req_mask;
`endif
  logic                  resp_valid;
  logic                  resp_ready;
  logic                  resp_hit;
  logic [ADDR_WIDTH-1:0] resp_addr;
  logic [1:0]            resp_status;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;

`ifdef CAM_TERNARY_EN
  modport master (
    output req_valid, req_op, req_key, req_mask, resp_ready,
    input  req_ready, resp_valid, resp_hit, resp_addr, resp_status, count, full
  );
  modport slave (
    input  req_valid, req_op, req_key, req_mask, resp_ready,
    output req_ready, resp_valid, resp_hit, resp_addr, resp_status, count, full
  );
`else
  modport master (
    output req_valid, req_op, req_key, resp_ready,
    input  req_ready, resp_valid, resp_hit, resp_addr, resp_status, count, full
  );
  modport slave (
    input  req_valid, req_op, req_key, resp_ready,
    output req_ready, resp_valid, resp_hit, resp_addr, resp_status, count, full
  );
`endif
endinterface

// File: rtl/cam_pipe.sv
// Two-stage pipelined CAM: S1 compares and updates the table, S2 priority-encodes
// into the response register. Optional ternary matching via CAM_TERNARY_EN.
module cam_pipe #(
  parameter int KEY_WIDTH  = 32,
  parameter int KEY_DEPTH  = 16,
  parameter int ADDR_WIDTH = $clog2(KEY_DEPTH)
) (
  input logic  clk,
  input logic  rst,
  cam_if.slave bus
);
  typedef enum logic [1:0] {
    OP_SEARCH = 2'b00,
    OP_INSERT = 2'b01,
    OP_DELETE = 2'b10,
    OP_FLUSH  = 2'b11
  } op_t;

  localparam logic [1:0]          ST_OK     = 2'b00;
  localparam logic [1:0]          ST_DUP    = 2'b01;
  localparam logic [1:0]          ST_FULL   = 2'b10;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(KEY_DEPTH);

  logic [KEY_DEPTH-1:0]  valid_reg;
  logic [KEY_DEPTH-1:0]  valid_next;
  logic [KEY_WIDTH-1:0]  key_reg [KEY_DEPTH];
`ifdef CAM_TERNARY_EN
  logic [KEY_WIDTH-1:0]  mask_reg [KEY_DEPTH];
  logic [KEY_WIDTH-1:0]  s1_mask_reg;
`endif
  logic [ADDR_WIDTH:0]   count_reg;
  logic [ADDR_WIDTH:0]   count_next;

  logic                  s1_valid_reg;
  op_t                   s1_op_reg;
  logic [KEY_WIDTH-1:0]  s1_key_reg;

  logic                  s2_valid_reg;
  op_t                   s2_op_reg;
  logic [KEY_DEPTH-1:0]  s2_match_reg;
  logic [ADDR_WIDTH-1:0] s2_free_reg;
  logic                  s2_full_reg;

  logic                  resp_valid_reg;
  logic                  resp_hit_reg;
  logic [ADDR_WIDTH-1:0] resp_addr_reg;
  logic [1:0]            resp_status_reg;

  logic                  stall;
  logic                  advance;
  logic                  s1_fire;
  logic [KEY_DEPTH-1:0]  cmp_match;
  logic [KEY_DEPTH-1:0]  dup_match;
  logic [KEY_DEPTH-1:0]  s1_match;
  logic [KEY_DEPTH-1:0]  write_en;
  logic [ADDR_WIDTH-1:0] free_idx;
  logic                  table_full;
  logic                  do_insert;

  logic                  s2_hit;
  logic [ADDR_WIDTH-1:0] s2_low_idx;
  logic                  resp_hit_next;
  logic [ADDR_WIDTH-1:0] resp_addr_next;
  logic [1:0]            resp_status_next;

  assign stall         = resp_valid_reg & ~bus.resp_ready;
  assign advance       = ~stall;
  assign s1_fire       = advance & s1_valid_reg;
  assign bus.req_ready = advance;

  // Search/delete use the stored mask; INSERT duplicates need identical key-on-mask and mask.
  for (genvar gi = 0; gi < KEY_DEPTH; gi++) begin : g_entry
`ifdef CAM_TERNARY_EN
    assign cmp_match[gi] = valid_reg[gi] &&
                           (((key_reg[gi] ^ s1_key_reg) & mask_reg[gi]) == '0);
    assign dup_match[gi] = valid_reg[gi] && (mask_reg[gi] == s1_mask_reg) &&
                           (((key_reg[gi] ^ s1_key_reg) & s1_mask_reg) == '0);
`else
    assign cmp_match[gi] = valid_reg[gi] && (key_reg[gi] == s1_key_reg);
    assign dup_match[gi] = cmp_match[gi];
`endif
    assign write_en[gi] = do_insert && (free_idx == ADDR_WIDTH'(gi));
  end

  always_comb begin
    free_idx = '0;
    for (int i = KEY_DEPTH - 1; i >= 0; i--) begin
      if (!valid_reg[i]) free_idx = ADDR_WIDTH'(i);
    end
  end

  assign table_full = &valid_reg;
  assign do_insert  = s1_fire && (s1_op_reg == OP_INSERT) && !(|dup_match) && !table_full;

  always_comb begin
    s1_match   = cmp_match;
    valid_next = valid_reg;
    case (s1_op_reg)
      OP_INSERT: s1_match = dup_match;
      OP_FLUSH:  s1_match = '0;
      default:   s1_match = cmp_match;
    endcase
    if (s1_fire) begin
      case (s1_op_reg)
        OP_INSERT: valid_next = valid_reg | write_en;
        OP_DELETE: valid_next = valid_reg & ~cmp_match;
        OP_FLUSH:  valid_next = '0;
        default:   valid_next = valid_reg;
      endcase
    end
  end

  // Count is a popcount of the next valid vector, so it lands on the write edge.
  always_comb begin
    count_next = '0;
    for (int i = 0; i < KEY_DEPTH; i++) begin
      count_next = count_next + (ADDR_WIDTH+1)'(valid_next[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
      count_reg <= '0;
      for (int i = 0; i < KEY_DEPTH; i++) begin
        key_reg[i] <= '0;
`ifdef CAM_TERNARY_EN
        mask_reg[i] <= '0;
`endif
      end
    end else begin
      valid_reg <= valid_next;
      count_reg <= count_next;
      for (int i = 0; i < KEY_DEPTH; i++) begin
        if (write_en[i]) begin
          key_reg[i] <= s1_key_reg;
`ifdef CAM_TERNARY_EN
          mask_reg[i] <= s1_mask_reg;
`endif
        end
      end
    end
  end

  always_comb begin
    s2_hit     = |s2_match_reg;
    s2_low_idx = '0;
    for (int i = KEY_DEPTH - 1; i >= 0; i--) begin
      if (s2_match_reg[i]) s2_low_idx = ADDR_WIDTH'(i);
    end
  end

  always_comb begin
    resp_hit_next    = s2_hit;
    resp_addr_next   = s2_low_idx;
    resp_status_next = ST_OK;
    case (s2_op_reg)
      OP_INSERT: begin
        if (s2_hit) begin
          resp_status_next = ST_DUP;
        end else if (s2_full_reg) begin
          resp_addr_next   = '0;
          resp_status_next = ST_FULL;
        end else begin
          resp_addr_next = s2_free_reg;
        end
      end
      OP_FLUSH: begin
        resp_hit_next  = 1'b0;
        resp_addr_next = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg    <= 1'b0;
      s1_op_reg       <= OP_SEARCH;
      s1_key_reg      <= '0;
`ifdef CAM_TERNARY_EN
      s1_mask_reg     <= '0;
`endif
      s2_valid_reg    <= 1'b0;
      s2_op_reg       <= OP_SEARCH;
      s2_match_reg    <= '0;
      s2_free_reg     <= '0;
      s2_full_reg     <= 1'b0;
      resp_valid_reg  <= 1'b0;
      resp_hit_reg    <= 1'b0;
      resp_addr_reg   <= '0;
      resp_status_reg <= ST_OK;
    end else if (advance) begin
      s1_valid_reg    <= bus.req_valid;
      s1_op_reg       <= op_t'(bus.req_op);
      s1_key_reg      <= bus.req_key;
`ifdef CAM_TERNARY_EN
      s1_mask_reg     <= bus.req_mask;
`endif
      s2_valid_reg    <= s1_valid_reg;
      s2_op_reg       <= s1_op_reg;
      s2_match_reg    <= s1_match;
      s2_free_reg     <= free_idx;
      s2_full_reg     <= table_full;
      resp_valid_reg  <= s2_valid_reg;
      if (s2_valid_reg) begin
        resp_hit_reg    <= resp_hit_next;
        resp_addr_reg   <= resp_addr_next;
        resp_status_reg <= resp_status_next;
      end
    end
  end

  assign bus.resp_valid  = resp_valid_reg;
  assign bus.resp_hit    = resp_hit_reg;
  assign bus.resp_addr   = resp_addr_reg;
  assign bus.resp_status = resp_status_reg;
  assign bus.count       = count_reg;
  assign bus.full        = (count_reg == DEPTH_CNT);
endmodule

// File: tb/tb_cam_pipe.sv
// Scoreboard bench for cam_pipe: driver applies a sequential CAM model at each
// accepted request and queues the expected response; a monitor pops and compares.
module tb_cam_pipe;
  localparam int KW = 32;
  localparam int KD = 16;
  localparam int AW = 4;

  typedef struct packed {
    logic          hit;
    logic [AW-1:0] addr;
    logic [1:0]    status;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cam_if #(.KEY_WIDTH(KW), .ADDR_WIDTH(AW)) bus ();

  cam_pipe #(.KEY_WIDTH(KW), .KEY_DEPTH(KD), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          errors  = 0;
  int          checks  = 0;
  int          rr_mode = 0;   // 0: always ready, 1: random, 2: held low
  bit          mv [KD];
  logic [31:0] mk [KD];
  logic [31:0] mm [KD];
  exp_t        expq [$];
  exp_t        mon_e;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < KD; i++) n += int'(mv[i]);
    return n;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < KD; i++) begin
      mv[i] = 1'b0;
      mk[i] = '0;
      mm[i] = '0;
    end
  endfunction

  // Sequential meaning of one request; the pipeline must look like this in order.
  function automatic exp_t model_apply(input logic [1:0] op, input logic [31:0] key,
                                       input logic [31:0] mask);
    exp_t r;
    int   low;
    r   = '0;
    low = -1;
    case (op)
      2'b00: begin
        for (int i = 0; i < KD; i++)
          if (low < 0 && mv[i] && ((mk[i] ^ key) & mm[i]) == 0) low = i;
        if (low >= 0) begin r.hit = 1'b1; r.addr = AW'(low); end
      end
      2'b01: begin
        for (int i = 0; i < KD; i++)
          if (low < 0 && mv[i] && mm[i] == mask && ((mk[i] ^ key) & mask) == 0) low = i;
        if (low >= 0) begin
          r.hit = 1'b1; r.addr = AW'(low); r.status = 2'b01;
        end else if (model_count() == KD) begin
          r.status = 2'b10;
        end else begin
          for (int i = 0; i < KD; i++) if (low < 0 && !mv[i]) low = i;
          mv[low] = 1'b1; mk[low] = key; mm[low] = mask;
          r.addr = AW'(low);
        end
      end
      2'b10: begin
        for (int i = 0; i < KD; i++) begin
          if (mv[i] && ((mk[i] ^ key) & mm[i]) == 0) begin
            if (low < 0) low = i;
            mv[i] = 1'b0;
          end
        end
        if (low >= 0) begin r.hit = 1'b1; r.addr = AW'(low); end
      end
      default: model_clear();
    endcase
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.resp_ready = (rr_mode == 0) ? 1'b1 :
                     (rr_mode == 1) ? ($urandom_range(0, 9) < 7) : 1'b0;
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] key, input logic [31:0] mask);
    bit done = 1'b0;
`ifndef CAM_TERNARY_EN
    mask = '1;
`endif
    for (int t = 0; t < 100 && !done; t++) begin
      tick();
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_key   = key;
`ifdef CAM_TERNARY_EN
      bus.req_mask  = mask;
`endif
      if (bus.req_ready) begin
        expq.push_back(model_apply(op, key, mask));
        done = 1'b1;
      end
    end
    if (!done) check("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    rr_mode = 0;
    for (int t = 0; t < 60 && expq.size() != 0; t++) tick();
    check("drain_empty", expq.size(), 0);
    tick();
    tick();
  endtask

  task automatic idle_check();
    drain();
    check("count", 32'(bus.count), model_count());
    check("full", 32'(bus.full), 32'(model_count() == KD));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.resp_valid && bus.resp_ready) begin
        if (expq.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          mon_e = expq.pop_front();
          check("resp_hit", 32'(bus.resp_hit), 32'(mon_e.hit));
          check("resp_addr", 32'(bus.resp_addr), 32'(mon_e.addr));
          check("resp_status", 32'(bus.resp_status), 32'(mon_e.status));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int r;
    logic [1:0]  op;
    logic [31:0] key;
    logic [31:0] mask;
    bus.req_valid  = 1'b0;
    bus.req_op     = 2'b00;
    bus.req_key    = '0;
`ifdef CAM_TERNARY_EN
    bus.req_mask   = '0;
`endif
    bus.resp_ready = 1'b1;
    model_clear();

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_resp_valid", 32'(bus.resp_valid), 0);
    check("rst_resp_hit", 32'(bus.resp_hit), 0);
    check("rst_resp_addr", 32'(bus.resp_addr), 0);
    check("rst_resp_status", 32'(bus.resp_status), 0);
    check("rst_count", 32'(bus.count), 0);
    check("rst_full", 32'(bus.full), 0);
    rst = 1'b0;
    #1;
    check("req_ready_after_rst", 32'(bus.req_ready), 1);

    // Single insert: latency and count timing
    issue(2'b01, 32'hA5, '1);
    tick();
    check("lat_cycle1_valid", 32'(bus.resp_valid), 0);
    tick();
    check("lat_cycle2_valid", 32'(bus.resp_valid), 0);
    check("count_after_insert", 32'(bus.count), 1);
    tick();
    check("lat_resp_valid", 32'(bus.resp_valid), 1);
    issue(2'b00, 32'hA5, '1);
    idle_check();

    // Fill to capacity, overflow, duplicate
    issue(2'b11, 32'h0, '1);
    for (int k = 0; k < KD; k++) issue(2'b01, 32'(k), '1);
    issue(2'b01, 32'h99, '1);
    idle_check();
    issue(2'b01, 32'h05, '1);

    // Freed slot reused by the immediately following insert
    issue(2'b10, 32'h03, '1);
    issue(2'b01, 32'h77, '1);
    idle_check();

    // Backpressure with three searches in flight
    drain();
    rr_mode = 2;
    issue(2'b00, 32'h05, '1);
    issue(2'b00, 32'h77, '1);
    issue(2'b00, 32'h99, '1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_req_ready", 32'(bus.req_ready), 0);
      check("stall_resp_valid", 32'(bus.resp_valid), 1);
    end
    idle_check();

`ifdef CAM_TERNARY_EN
    issue(2'b11, 32'h0, '1);
    issue(2'b01, 32'h1200, 32'hFF00);
    issue(2'b00, 32'h12AB, '1);
    issue(2'b00, 32'h13AB, '1);
    idle_check();
`endif

    // Reset with two requests in flight
    issue(2'b11, 32'h0, '1);
    issue(2'b01, 32'h42, '1);
    drain();
    issue(2'b00, 32'h42, '1);
    issue(2'b01, 32'h43, '1);
    tick();
    rst = 1'b1;
    expq.delete();
    model_clear();
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("post_rst_count", 32'(bus.count), 0);
    check("post_rst_resp_valid", 32'(bus.resp_valid), 0);
    issue(2'b00, 32'h42, '1);
    idle_check();

    // Randomized traffic with random backpressure
    rr_mode = 1;
    for (int n = 0; n < 400; n++) begin
      r   = int'($urandom_range(0, 99));
      key = 32'($urandom_range(0, 23));
`ifdef CAM_TERNARY_EN
      mask = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : 32'hFFFF_FFFF;
`else
      mask = '1;
`endif
      op = (r < 35) ? 2'b01 : (r < 65) ? 2'b00 : (r < 92) ? 2'b10 : 2'b11;
      if (r < 94) issue(op, key, mask);
      else tick();
      rr_mode = 1;
    end
    idle_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cam_pipe.md
CAM_PIPE -- requirements
Module: cam_pipe

Interface
REQ-001 Parameter KEY_WIDTH, 32, key width in bits.
REQ-002 Parameter KEY_DEPTH, 16, number of entries; power of two, >= 2.
REQ-003 Parameter ADDR_WIDTH, $clog2(KEY_DEPTH), entry index width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  request accepted when req_valid & req_ready at an edge.
REQ-008 req_op  in  2  00 SEARCH, 01 INSERT, 10 DELETE, 11 FLUSH.
REQ-009 req_key  in  KEY_WIDTH  key operand.
REQ-010 req_mask  in  KEY_WIDTH  care mask, 1 = bit compared; present only with CAM_TERNARY_EN.
REQ-011 resp_valid  out  1  response present.
REQ-012 resp_ready  in  1  response consumed when resp_valid & resp_ready.
REQ-013 resp_hit  out  1  key matched at least one valid entry.
REQ-014 resp_addr  out  ADDR_WIDTH  lowest matching index, or written index for INSERT.
REQ-015 resp_status  out  2  00 OK, 01 DUP, 10 FULL, 11 reserved (never driven).
REQ-016 count  out  ADDR_WIDTH+1  number of valid entries.
REQ-017 full  out  1  count == KEY_DEPTH.

Function
REQ-018 Two-stage pipeline: S1 compares and updates the table; S2 priority-encodes and holds the response; response appears 2 cycles after acceptance.
REQ-019 stall = resp_valid & ~resp_ready; while stalled both stages hold, no table update occurs, req_ready = 0; otherwise req_ready = 1.
REQ-020 Throughput one request per cycle without stall; each request observes every table update of all earlier-accepted requests (no hazards).
REQ-021 Match for entry i: valid[i] and stored key equals req_key on all compared bits.
REQ-022 SEARCH: no table change; resp_hit = any match; resp_addr = lowest matching index, 0 on miss; status OK.
REQ-023 INSERT with an existing match: no write; hit 1, addr = lowest match, status DUP.
REQ-024 INSERT without match, not full: write key into lowest-index invalid entry, set valid; hit 0, addr = that index, status OK.
REQ-025 INSERT without match when full: no write; hit 0, addr 0, status FULL.
REQ-026 DELETE: clear valid of every matching entry in the same S1 cycle; hit = any match, addr = lowest match (0 on miss), status OK.
REQ-027 FLUSH: clear all valid bits in S1; hit 0, addr 0, status OK.
REQ-028 count and full update on the edge the S1 write occurs; count changes by +1 (INSERT), -N (DELETE, N matches), or to 0 (FLUSH).
REQ-029 Freed slots are reusable by the very next accepted INSERT.

Reset
REQ-030 On rst: all valid bits 0, stored keys/masks 0, S1/S2 valid 0, resp_valid 0, resp_hit 0, resp_addr 0, resp_status 00, count 0, full 0.
REQ-031 rst asserted mid-operation discards in-flight requests; no response is produced for them.
REQ-032 req_ready = 1 in the first cycle after rst deasserts.

Configuration
REQ-033 Macro CAM_TERNARY_EN defined: each entry stores a mask with the key; bit b compared only where stored mask[b] = 1; INSERT stores req_mask; DUP requires equal key-on-mask and equal mask.
REQ-034 Macro CAM_TERNARY_EN undefined: req_mask port and mask storage absent; all KEY_WIDTH bits compared.

Verification
REQ-035 After reset, INSERT 0xA5 -> response 2 cycles later: hit 0, addr 0, OK, count 1; SEARCH 0xA5 -> hit 1, addr 0.
REQ-036 INSERT keys 0..15 back-to-back, then INSERT 0x99 -> addrs 0..15 OK, then FULL with full = 1, count 16; INSERT 0x05 -> DUP, addr 5.
REQ-037 Full table, DELETE 0x03 then INSERT 0x77 on the next cycle -> DELETE hit addr 3; INSERT addr 3 OK; count returns to 16.
REQ-038 Hold resp_ready = 0 for 5 cycles with 3 SEARCHes queued -> req_ready low during stall, responses delivered in order, none lost or duplicated.
REQ-039 Ternary build: INSERT key 0x1200, mask 0xFF00 -> SEARCH 0x12AB hit addr 0; SEARCH 0x13AB miss.
REQ-040 Assert rst with two requests in flight -> no responses, count 0, SEARCH of prior key misses.
